// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: hardware clear of x1..x(DEPTH-1) after reset, then
// round-robin sharing of the write port between NUM_REQ writeback sources. Option: INIT_SP_EN.
module regfile_wb_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          REGISTER_DEPTH = 32,
    parameter logic [31:0] STACKADDR      = 32'hffff_ffff
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic                    rf_we,
    output logic [4:0]              rf_A3,
    output logic [31:0]             rf_wd,
    output logic                    init_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_nxt;
    logic [4:0]         idx, idx_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt;
    logic               we_nxt, busy_nxt;
    logic [4:0]         a3_nxt;
    logic [31:0]        wd_nxt, init_wd;
    logic               gnt_vld;
    int                 gi, j;
    logic [4:0]         sel_addr;
    logic [31:0]        sel_data;

    // First valid requester at or above rr_ptr, wrapping; nothing is granted in INIT or reset.
    always_comb begin
        gnt_vld = 1'b0;
        gi      = 0;
        j       = 0;
        if (state == RUN && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (int'(rr_ptr) + k) % NUM_REQ;
                if (!gnt_vld && req_valid[j]) begin
                    gnt_vld = 1'b1;
                    gi      = j;
                end
            end
        end
        req_ready = gnt_vld ? (NUM_REQ'(1) << gi) : '0;
        sel_addr  = req_addr[gi*5 +: 5];
        sel_data  = req_data[gi*32 +: 32];
    end

`ifdef INIT_SP_EN
    assign init_wd = (idx == 5'd2) ? STACKADDR : 32'h0;
`else
    assign init_wd = STACKADDR & 32'h0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rr_nxt    = rr_ptr;
        we_nxt    = 1'b0;
        a3_nxt    = rf_A3;
        wd_nxt    = rf_wd;
        busy_nxt  = init_busy;
        case (state)
            INIT: begin
                we_nxt  = 1'b1;
                a3_nxt  = idx;
                wd_nxt  = init_wd;
                idx_nxt = idx + 5'd1;
                if (idx == 5'(REGISTER_DEPTH-1)) begin
                    state_nxt = RUN;
                    busy_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (gnt_vld) begin
                    rr_nxt = (gi == NUM_REQ-1) ? '0 : PTR_W'(gi + 1);
                    a3_nxt = sel_addr;
                    wd_nxt = sel_data;
                    // x0 and out-of-range targets are accepted but never written
                    we_nxt = (sel_addr != 5'd0) && ({1'b0, sel_addr} < 6'(REGISTER_DEPTH));
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            idx       <= 5'd1;
            rr_ptr    <= '0;
            rf_we     <= 1'b0;
            rf_A3     <= 5'd0;
            rf_wd     <= 32'h0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rr_ptr    <= rr_nxt;
            rf_we     <= we_nxt;
            rf_A3     <= a3_nxt;
            rf_wd     <= wd_nxt;
            init_busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a DEPTH=32 instance is tracked write by write,
// a DEPTH=16 twin on the same inputs covers the out-of-range drop and its shorter clear.
module tb_regfile_wb_arbiter;

    localparam int          NR    = 2;
    localparam logic [31:0] STACK = 32'h0001_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*5-1:0] req_addr  = '0;
    logic [NR*32-1:0] req_data = '0;

    logic [NR-1:0]   ready32, ready16;
    logic            we32, we16, busy32, busy16;
    logic [4:0]      a3_32, a3_16;
    logic [31:0]     wd32, wd16;

    regfile_wb_arbiter #(.NUM_REQ(NR), .REGISTER_DEPTH(32), .STACKADDR(STACK)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready32),
        .req_addr(req_addr), .req_data(req_data),
        .rf_we(we32), .rf_A3(a3_32), .rf_wd(wd32), .init_busy(busy32));

    regfile_wb_arbiter #(.NUM_REQ(NR), .REGISTER_DEPTH(16), .STACKADDR(STACK)) u16 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready16),
        .req_addr(req_addr), .req_data(req_data),
        .rf_we(we16), .rf_A3(a3_16), .rf_wd(wd16), .init_busy(busy16));

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  a3;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write the port produces must be the oldest expected one, in its exact cycle.
    always @(negedge clk) begin
        wr_t e;
        if (we32 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d got A3=%0d wd=%h required no write", cyc, a3_32, wd32);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc !== cyc || a3_32 !== e.a3 || wd32 !== e.wd) begin
                    errors++;
                    $display("FAIL write cyc=%0d got A3=%0d wd=%h required cyc=%0d A3=%0d wd=%h",
                             cyc, a3_32, wd32, e.cyc, e.a3, e.wd);
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL missing_write cyc=%0d got rf_we=%b required A3=%0d wd=%h", cyc, we32, e.a3, e.wd);
        end
    end

    function automatic logic [31:0] init_val(int k);
`ifdef INIT_SP_EN
        return (k == 2) ? STACK : 32'h0;
`else
        return 32'h0;
`endif
    endfunction

    task automatic push(int c, logic [4:0] a, logic [31:0] d);
        wr_t e;
        e.cyc = c; e.a3 = a; e.wd = d;
        exp_q.push_back(e);
    endtask

    task automatic set_req(int r, logic v, logic [4:0] a, logic [31:0] d);
        req_valid[r]       = v;
        req_addr[r*5 +: 5] = a;
        req_data[r*32 +: 32] = d;
    endtask

    task automatic chk_ready(string nm, logic [NR-1:0] got, logic [NR-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got ready=%b required %b", nm, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (we32 !== 1'b0 || a3_32 !== 5'd0 || wd32 !== 32'h0 || busy32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got we=%b A3=%0d wd=%h busy=%b required 0 0 0 1",
                     we32, a3_32, wd32, busy32);
        end
        req_valid = '1;
        #1 chk_ready("reset_ready", ready32, '0);
        req_valid = '0;
    endtask

    // Release reset and expect the 31-write clear; requests held valid must not be granted.
    task automatic test_init();
        rst = 1'b0;
        #1;
        for (int k = 1; k < 32; k++) push(cyc + k, 5'(k), init_val(k));
        for (int i = 0; i < 31; i++) begin
            req_valid = (i < 30) ? '1 : '0;
            #1;
            checks++;
            if (busy32 !== 1'b1 || ready32 !== '0) begin
                errors++;
                $display("FAIL init_busy i=%0d got busy=%b ready=%b required 1 00", i, busy32, ready32);
            end
            checks++;
            if (busy16 !== (i < 15)) begin
                errors++;
                $display("FAIL init_busy16 i=%0d got %b required %b", i, busy16, (i < 15));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (busy32 !== 1'b0 || ready32 !== '0) begin
            errors++;
            $display("FAIL init_done got busy=%b ready=%b required 0 00", busy32, ready32);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(0, 1'b1, 5'd5, 32'hdead_beef);
        #1 chk_ready("single_ready", ready32, 2'b01);
        push(cyc + 1, 5'd5, 32'hdead_beef);
        @(negedge clk);
        req_valid = '0;
    endtask

    // rr_ptr is 1 here: requester 1 writes x0, accepted but dropped, pointer wraps to 0.
    task automatic test_drop_x0();
        @(negedge clk);
        set_req(1, 1'b1, 5'd0, 32'h0000_1234);
        #1 chk_ready("drop_ready", ready32, 2'b10);
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (we32 !== 1'b0) begin
            errors++;
            $display("FAIL drop_we got %b required 0", we32);
        end
    endtask

    // Both valid: grants must alternate starting at 0; losers hold their request.
    task automatic test_round_robin();
        int n[NR];
        logic [NR-1:0] exp_r;
        n[0] = 0; n[1] = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < NR; r++)
                set_req(r, 1'b1, 5'(8 + 4*r + n[r]), 32'hA000_0000 + 32'(r*16 + n[r]));
            exp_r = NR'(1) << (k % 2);
            #1 chk_ready($sformatf("rr_ready%0d", k), ready32, exp_r);
            push(cyc + 1, 5'(8 + 4*(k%2) + n[k%2]), 32'hA000_0000 + 32'((k%2)*16 + n[k%2]));
            n[k%2]++;
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_drop_range();
        @(negedge clk);
        set_req(0, 1'b1, 5'd20, 32'h5555_aaaa);
        #1 chk_ready("range_ready32", ready32, 2'b01);
        chk_ready("range_ready16", ready16, 2'b01);
        push(cyc + 1, 5'd20, 32'h5555_aaaa);
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (we16 !== 1'b0) begin
            errors++;
            $display("FAIL range_we16 got %b required 0", we16);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 5'(k + 1), 32'hB0B0_0000 + 32'(k));
            #1 chk_ready($sformatf("b2b_ready%0d", k), ready32, 2'b01);
            push(cyc + 1, 5'(k + 1), 32'hB0B0_0000 + 32'(k));
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    // rr_ptr is 1: requester 0 loses, then withdraws before any grant.
    task automatic test_withdraw();
        @(negedge clk);
        set_req(0, 1'b1, 5'd3, 32'h0303_0303);
        set_req(1, 1'b1, 5'd4, 32'h0404_0404);
        #1 chk_ready("wd_ready", ready32, 2'b10);
        push(cyc + 1, 5'd4, 32'h0404_0404);
        @(negedge clk);
        req_valid = '0;
        #1 chk_ready("wd_idle", ready32, 2'b00);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        set_req(0, 1'b1, 5'd7, 32'h7777_0007);
        #1 chk_ready("mid_ready", ready32, 2'b01);
        push(cyc + 1, 5'd7, 32'h7777_0007);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_ready("mid_rst_ready", ready32, 2'b00);
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (we32 !== 1'b0 || busy32 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got we=%b busy=%b required 0 1", we32, busy32);
        end
        test_init();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_single();
        test_drop_x0();
        test_round_robin();
        test_drop_range();
        test_back_to_back();
        test_withdraw();
        test_reset_midop();
        test_single();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
